// File: rtl/control_fsm.sv
// Control state machine for the transaction-layer FIFO bank: sequences reset,
// threshold configuration, idle/active operation and a terminal error state.
module control_fsm #(
    parameter int N_FIFO   = 4,
    parameter int UMBRAL_W = 3
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_superior_in,
    input  logic [UMBRAL_W-1:0] umbral_inferior_in,
    input  logic [N_FIFO-1:0]   fifo_empty,
    input  logic [N_FIFO-1:0]   fifo_error,
    output logic [3:0]          state,
    output logic [UMBRAL_W-1:0] umbral_superior,
    output logic [UMBRAL_W-1:0] umbral_inferior,
    output logic                idle,
    output logic                error_out,
    output logic [N_FIFO-1:0]   error_fifo,
    output logic                cfg_error
);

    localparam logic [3:0] ST_RESET  = 4'd0;
    localparam logic [3:0] ST_INIT   = 4'd1;
    localparam logic [3:0] ST_IDLE   = 4'd2;
    localparam logic [3:0] ST_ACTIVE = 4'd3;
    localparam logic [3:0] ST_ERROR  = 4'd4;

    logic [3:0]          state_reg, state_next;
    logic [UMBRAL_W-1:0] sup_reg, sup_next;
    logic [UMBRAL_W-1:0] inf_reg, inf_next;
    logic                idle_reg, idle_next;
    logic                err_reg, err_next;
    logic [N_FIFO-1:0]   error_fifo_reg, error_fifo_next;
    logic                cfg_error_reg, cfg_error_next;

    // Comparison is on the raw inputs so a bad pair is caught on the edge it is offered.
    logic thr_legal;
    assign thr_legal = (umbral_inferior_in < umbral_superior_in);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_reg      <= ST_RESET;
            sup_reg        <= '0;
            inf_reg        <= '0;
            idle_reg       <= 1'b0;
            err_reg        <= 1'b0;
            error_fifo_reg <= '0;
            cfg_error_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sup_reg        <= sup_next;
            inf_reg        <= inf_next;
            idle_reg       <= idle_next;
            err_reg        <= err_next;
            error_fifo_reg <= error_fifo_next;
            cfg_error_reg  <= cfg_error_next;
        end
    end

    always_comb begin
        state_next = ST_RESET;
        case (state_reg)
            ST_RESET: state_next = ST_INIT;
            ST_INIT: begin
                if (init)           state_next = ST_INIT;
                else if (thr_legal) state_next = ST_IDLE;
                else                state_next = ST_ERROR;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (|fifo_error)      state_next = ST_ERROR;
                else if (init)        state_next = ST_INIT;
                else if (&fifo_empty) state_next = ST_IDLE;
                else                  state_next = ST_ACTIVE;
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RESET;
        endcase
    end

    always_comb begin
        sup_next        = sup_reg;
        inf_next        = inf_reg;
        cfg_error_next  = cfg_error_reg;
        error_fifo_next = error_fifo_reg;
        if (state_reg == ST_INIT) begin
            if (init || thr_legal) begin
                sup_next = umbral_superior_in;
                inf_next = umbral_inferior_in;
            end else begin
                cfg_error_next = 1'b1;
            end
        end
        // Error pulses are accumulated in every state that watches the FIFOs, ERROR included.
        if (state_reg == ST_IDLE || state_reg == ST_ACTIVE || state_reg == ST_ERROR)
            error_fifo_next = error_fifo_reg | fifo_error;
        idle_next = (state_next == ST_IDLE);
        err_next  = (state_next == ST_ERROR);
    end

    assign state           = state_reg;
    assign umbral_superior = sup_reg;
    assign umbral_inferior = inf_reg;
    assign idle            = idle_reg;
    assign error_out       = err_reg;
    assign error_fifo      = error_fifo_reg;
    assign cfg_error       = cfg_error_reg;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the control rules.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [2:0] sup_in;
    logic [2:0] inf_in;
    logic [3:0] fifo_empty;
    logic [3:0] fifo_error;
    logic [3:0] state;
    logic [2:0] umbral_superior;
    logic [2:0] umbral_inferior;
    logic       idle;
    logic       error_out;
    logic [3:0] error_fifo;
    logic       cfg_error;

    int tests = 0;
    int fails = 0;

    // Reference model state (spec encodings of the state code)
    int         m_state = 0;
    logic [2:0] m_sup = '0;
    logic [2:0] m_inf = '0;
    logic [3:0] m_efifo = '0;
    logic       m_cfg = 1'b0;

    control_fsm #(.N_FIFO(4), .UMBRAL_W(3)) dut (
        .clk                (clk),
        .reset_L            (reset_L),
        .init               (init),
        .umbral_superior_in (sup_in),
        .umbral_inferior_in (inf_in),
        .fifo_empty         (fifo_empty),
        .fifo_error         (fifo_error),
        .state              (state),
        .umbral_superior    (umbral_superior),
        .umbral_inferior    (umbral_inferior),
        .idle               (idle),
        .error_out          (error_out),
        .error_fifo         (error_fifo),
        .cfg_error          (cfg_error)
    );

    always #5 clk = ~clk;

    // Apply the control rules to the inputs present at the coming edge.
    task automatic model_update();
        if (!reset_L) begin
            m_state = 0; m_sup = '0; m_inf = '0; m_efifo = '0; m_cfg = 1'b0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (init || (int'(inf_in) < int'(sup_in))) begin
                m_sup = sup_in;
                m_inf = inf_in;
                m_state = init ? 1 : 2;
            end else begin
                m_cfg = 1'b1;
                m_state = 4;
            end
        end else if (m_state == 2 || m_state == 3) begin
            if (fifo_error != 0) begin
                m_efifo = m_efifo | fifo_error;
                m_state = 4;
            end else if (init) begin
                m_state = 1;
            end else begin
                m_state = (fifo_empty == 4'hF) ? 2 : 3;
            end
        end else begin
            m_efifo = m_efifo | fifo_error;
        end
    endtask

    task automatic check(input string tag);
        logic [3:0] exp_state;
        exp_state = 4'(m_state);
        tests++;
        assert (state === exp_state) else begin
            fails++; $error("FAIL %s state got=%0d exp=%0d", tag, state, exp_state);
        end
        tests++;
        assert (umbral_superior === m_sup) else begin
            fails++; $error("FAIL %s umbral_superior got=%0d exp=%0d", tag, umbral_superior, m_sup);
        end
        tests++;
        assert (umbral_inferior === m_inf) else begin
            fails++; $error("FAIL %s umbral_inferior got=%0d exp=%0d", tag, umbral_inferior, m_inf);
        end
        tests++;
        assert (idle === (m_state == 2)) else begin
            fails++; $error("FAIL %s idle got=%b exp=%b", tag, idle, (m_state == 2));
        end
        tests++;
        assert (error_out === (m_state == 4)) else begin
            fails++; $error("FAIL %s error_out got=%b exp=%b", tag, error_out, (m_state == 4));
        end
        tests++;
        assert (error_fifo === m_efifo) else begin
            fails++; $error("FAIL %s error_fifo got=%b exp=%b", tag, error_fifo, m_efifo);
        end
        tests++;
        assert (cfg_error === m_cfg) else begin
            fails++; $error("FAIL %s cfg_error got=%b exp=%b", tag, cfg_error, m_cfg);
        end
        $display("[TB] %-10s rst_L=%b init=%b sup_in=%0d inf_in=%0d empty=%b ferr=%b -> state=%0d thr=%0d/%0d idle=%b err=%b efifo=%b cfg=%b",
                 tag, reset_L, init, sup_in, inf_in, fifo_empty, fifo_error,
                 state, umbral_superior, umbral_inferior, idle, error_out, error_fifo, cfg_error);
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; sup_in = 3'd6; inf_in = 3'd1;
        fifo_empty = 4'hF; fifo_error = 4'h0;

        // Reset then configure
        step("rst0"); step("rst1");
        reset_L = 1'b1;
        step("to_init"); step("to_idle");

        // Activity tracking
        fifo_empty = 4'b1110;
        step("act0"); step("act1"); step("act2");
        fifo_empty = 4'b1111;
        step("back_idle");

        // Error capture and stickiness in ERROR
        fifo_empty = 4'b1110;
        step("active");
        fifo_error = 4'b0100; step("err_pulse");
        fifo_error = 4'b0000; step("err_hold");
        fifo_error = 4'b0001; step("err_or");
        fifo_error = 4'b0000; init = 1'b1;
        step("err_init0"); step("err_init1");
        init = 1'b0;

        // Illegal configuration
        reset_L = 1'b0; step("rst_err");
        reset_L = 1'b1; init = 1'b1;
        step("cfg_init0"); step("cfg_init1");
        init = 1'b0; sup_in = 3'd2; inf_in = 3'd2;
        step("cfg_bad");

        // Priority: error beats init beats activity
        reset_L = 1'b0; step("rst_p0");
        reset_L = 1'b1; sup_in = 3'd6; inf_in = 3'd1; fifo_empty = 4'hF;
        step("p0_init"); step("p0_idle");
        fifo_error = 4'b0001; init = 1'b1; fifo_empty = 4'h0;
        step("prio_err");
        fifo_error = 4'h0; init = 1'b0; fifo_empty = 4'hF;
        reset_L = 1'b0; step("rst_p1");
        reset_L = 1'b1; step("p1_init"); step("p1_idle");
        init = 1'b1; fifo_empty = 4'h0;
        step("prio_init");
        init = 1'b0; step("p1_reidle");

        // Reconfigure from ACTIVE, then reset out of ERROR
        step("p1_active");
        init = 1'b1; sup_in = 3'd5; inf_in = 3'd2;
        step("recfg0"); step("recfg1");
        init = 1'b0; step("recfg_idle");
        fifo_error = 4'b1000; step("to_err");
        fifo_error = 4'h0; reset_L = 1'b0; step("rst_clear");
        reset_L = 1'b1;

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            reset_L    = ($urandom_range(0, 19) != 0);
            init       = ($urandom_range(0, 3) == 0);
            sup_in     = 3'($urandom_range(0, 7));
            inf_in     = 3'($urandom_range(0, 7));
            fifo_empty = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            fifo_error = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
